// File: rtl/wr_beat_accountant.sv
// wr_beat_accountant
// Write-beat bookkeeping for the AXI write monitor. Keeps a FIFO of AW burst
// lengths, checks each W burst against the length of the burst at the FIFO
// head, and tracks the running count of beats that were accepted on AW but not
// yet seen on W. It also provides the per-AW timeout budget and the prescaled
// countdown tick used by the transaction manager.
module wr_beat_accountant #(
    parameter int MaxWrTxns    = 8,
    parameter int PrescalerDiv = 1,
    parameter int AccuCntWidth = 10
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    aw_hs_i,
    input  logic [7:0]              aw_len_i,
    input  logic                    w_hs_i,
    input  logic                    w_last_i,
    input  logic                    flush_i,
    output logic                    aw_stall_o,
    output logic [AccuCntWidth-1:0] accum_burst_length_o,
    output logic [AccuCntWidth-1:0] txn_budget_o,
    output logic                    tick_o,
    output logic                    w_unexpected_o,
    output logic                    w_last_err_o,
    output logic                    fifo_ovf_o
);

    localparam int PtrW    = (MaxWrTxns > 1) ? $clog2(MaxWrTxns) : 1;
    localparam int CntW    = $clog2(MaxWrTxns + 1);
    localparam int PsW     = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;
    localparam int PsShift = $clog2(PrescalerDiv);
    // Wide enough for accum + 256 without wrapping, whatever AccuCntWidth is.
    localparam int SumW    = ((AccuCntWidth > 8) ? AccuCntWidth : 8) + 2;

    localparam logic [SumW-1:0] AccuMax  = SumW'({AccuCntWidth{1'b1}});
    localparam logic [PtrW-1:0] PtrLast  = PtrW'(MaxWrTxns - 1);
    localparam logic [CntW-1:0] CntFull  = CntW'(MaxWrTxns);
    localparam logic [PsW-1:0]  PsLast   = PsW'(PrescalerDiv - 1);

    // Clamp a wide intermediate to the largest value the counter can hold.
    function automatic logic [AccuCntWidth-1:0] sat_accu(input logic [SumW-1:0] v);
        if (v > AccuMax) begin
            return '1;
        end
        return v[AccuCntWidth-1:0];
    endfunction

    // FIFO pointers wrap at MaxWrTxns, which need not be a power of two.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        if (p == PtrLast) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    logic [7:0]              r_mem [MaxWrTxns];
    logic [PtrW-1:0]         r_wr_ptr;
    logic [PtrW-1:0]         r_rd_ptr;
    logic [CntW-1:0]         r_count;
    logic [7:0]              r_beat_cnt;
    logic [AccuCntWidth-1:0] r_accum;
    logic [PsW-1:0]          r_ps_cnt;
    logic                    r_tick;
    logic                    r_w_unexp;
    logic                    r_w_last_err;
    logic                    r_fifo_ovf;

    logic                    w_empty;
    logic                    w_full;
    logic                    w_w_acc;
    logic [7:0]              w_head_len;
    logic                    w_end_cnt;
    logic                    w_burst_end;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_bypass;
    logic                    w_wr_en;
    logic                    w_rd_en;
    logic                    w_ovf_evt;
    logic [SumW-1:0]         w_sum;
    logic [SumW-1:0]         w_accum_raw;
    logic [SumW-1:0]         w_budget_raw;

    // Burst tracking, FIFO steering, accumulator and budget arithmetic.
    always_comb begin
        w_empty      = (r_count == '0);
        w_full       = (r_count == CntFull);
        // A W beat is only accounted when some burst (stored or arriving now) owns it.
        w_w_acc      = w_hs_i && (!w_empty || aw_hs_i);
        w_head_len   = w_empty ? aw_len_i : r_mem[r_rd_ptr];
        w_end_cnt    = (r_beat_cnt == w_head_len);
        w_burst_end  = w_end_cnt || w_last_i;
        w_pop        = w_w_acc && w_burst_end;
        // A full FIFO still accepts an AW when the head leaves in the same cycle.
        w_push       = aw_hs_i && (!w_full || w_pop);
        w_ovf_evt    = aw_hs_i && w_full && !w_pop;
        // Single-beat burst arriving on AW and W together never needs storage.
        w_bypass     = w_empty && w_push && w_pop;
        w_wr_en      = w_push && !w_bypass;
        w_rd_en      = w_pop && !w_bypass;

        w_sum        = SumW'(r_accum) + (aw_hs_i ? (SumW'(aw_len_i) + 1'b1) : '0);
        w_accum_raw  = (w_w_acc && (w_sum != '0)) ? (w_sum - 1'b1) : w_sum;

        w_budget_raw = ((SumW'(r_accum) + SumW'(aw_len_i) + 1'b1) >> PsShift) + 1'b1;
    end

    // Length storage; contents are meaningless outside the valid window.
    always_ff @(posedge clk_i) begin
        if (w_wr_en && !flush_i && !rst_i) begin
            r_mem[r_wr_ptr] <= aw_len_i;
        end
    end

    // Control state: pointers, counters, error pulses and the sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_beat_cnt   <= '0;
            r_accum      <= '0;
            r_ps_cnt     <= '0;
            r_tick       <= 1'b0;
            r_w_unexp    <= 1'b0;
            r_w_last_err <= 1'b0;
            r_fifo_ovf   <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_rd_en) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (w_wr_en && !w_rd_en) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr_en && w_rd_en) begin
                r_count <= r_count - 1'b1;
            end

            if (w_w_acc) begin
                r_beat_cnt <= w_burst_end ? 8'd0 : (r_beat_cnt + 8'd1);
            end

            r_accum      <= sat_accu(w_accum_raw);

            r_ps_cnt     <= (r_ps_cnt == PsLast) ? '0 : (r_ps_cnt + 1'b1);
            r_tick       <= (r_ps_cnt == PsLast);

            r_w_unexp    <= w_hs_i && w_empty && !aw_hs_i;
            r_w_last_err <= w_w_acc && (w_end_cnt != w_last_i);

            if (w_ovf_evt) begin
                r_fifo_ovf <= 1'b1;
            end
        end
    end

    assign aw_stall_o           = w_full;
    assign accum_burst_length_o = r_accum;
    assign txn_budget_o         = sat_accu(w_budget_raw);
    assign tick_o               = r_tick;
    assign w_unexpected_o       = r_w_unexp;
    assign w_last_err_o         = r_w_last_err;
    assign fifo_ovf_o           = r_fifo_ovf;

endmodule

// File: tb/tb_wr_beat_accountant.sv
// Bench for wr_beat_accountant: table of per-cycle vectors checked through a
// scoreboard queue, plus hand sequences for the budget and the prescaled tick.
module tb_wr_beat_accountant;

    localparam int AW = 10;

    logic          clk;
    logic          rst;
    logic          aw_hs;
    logic [7:0]    aw_len;
    logic          w_hs;
    logic          w_last;
    logic          flush;
    logic          aw_stall;
    logic [AW-1:0] accum;
    logic [AW-1:0] budget;
    logic          tick;
    logic          w_unexp;
    logic          w_lerr;
    logic          ovf;

    int total = 0;
    int bad   = 0;

    wr_beat_accountant #(
        .MaxWrTxns   (8),
        .PrescalerDiv(4),
        .AccuCntWidth(AW)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .aw_hs_i             (aw_hs),
        .aw_len_i            (aw_len),
        .w_hs_i              (w_hs),
        .w_last_i            (w_last),
        .flush_i             (flush),
        .aw_stall_o          (aw_stall),
        .accum_burst_length_o(accum),
        .txn_budget_o        (budget),
        .tick_o              (tick),
        .w_unexpected_o      (w_unexp),
        .w_last_err_o        (w_lerr),
        .fifo_ovf_o          (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          flush;
        logic          aw;
        logic [7:0]    len;
        logic          w;
        logic          last;
        logic [AW-1:0] e_accum;
        logic          e_stall;
        logic          e_unexp;
        logic          e_lerr;
        logic          e_ovf;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic f, input logic a, input int l,
                       input logic w, input logic lst, input int ea, input logic es,
                       input logic eu, input logic el, input logic eo);
        vec_t v;
        v.rst = r; v.flush = f; v.aw = a; v.len = 8'(l); v.w = w; v.last = lst;
        v.e_accum = AW'(ea); v.e_stall = es; v.e_unexp = eu; v.e_lerr = el; v.e_ovf = eo;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic f, input logic a, input logic [7:0] l,
                         input logic w, input logic lst);
        rst = r; flush = f; aw_hs = a; aw_len = l; w_hs = w; w_last = lst;
    endtask

    initial begin
        vec_t e;
        drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

        //  rst flush aw len w last | accum stall unexp lerr ovf
        add(1, 0, 0, 0,   0, 0,   0, 0, 0, 0, 0);   // reset state
        add(0, 0, 0, 0,   0, 0,   0, 0, 0, 0, 0);
        // len=3 burst, four beats, last on the fourth
        add(0, 0, 1, 3,   0, 0,   4, 0, 0, 0, 0);
        add(0, 0, 0, 0,   1, 0,   3, 0, 0, 0, 0);
        add(0, 0, 0, 0,   1, 0,   2, 0, 0, 0, 0);
        add(0, 0, 0, 0,   1, 0,   1, 0, 0, 0, 0);
        add(0, 0, 0, 0,   1, 1,   0, 0, 0, 0, 0);
        add(0, 0, 0, 0,   0, 0,   0, 0, 0, 0, 0);
        // W with nothing outstanding
        add(0, 0, 0, 0,   1, 0,   0, 0, 1, 0, 0);
        add(0, 0, 0, 0,   0, 0,   0, 0, 0, 0, 0);
        // AW and first W in the same cycle on an empty FIFO
        add(0, 0, 1, 1,   1, 0,   1, 0, 0, 0, 0);
        add(0, 0, 0, 0,   1, 1,   0, 0, 0, 0, 0);
        add(0, 0, 0, 0,   0, 0,   0, 0, 0, 0, 0);
        // len=2 burst ending early on beat 2
        add(0, 0, 1, 2,   0, 0,   3, 0, 0, 0, 0);
        add(0, 0, 0, 0,   1, 0,   2, 0, 0, 0, 0);
        add(0, 0, 0, 0,   1, 1,   1, 0, 0, 1, 0);
        add(0, 0, 0, 0,   0, 0,   1, 0, 0, 0, 0);
        // next burst starts from beat 0 again
        add(0, 0, 1, 1,   0, 0,   3, 0, 0, 0, 0);
        add(0, 0, 0, 0,   1, 0,   2, 0, 0, 0, 0);
        add(0, 0, 0, 0,   1, 1,   1, 0, 0, 0, 0);
        // FIFO now empty: beat is unexpected, accum untouched
        add(0, 0, 0, 0,   1, 0,   1, 0, 1, 0, 0);
        add(0, 1, 0, 0,   0, 0,   0, 0, 0, 0, 0);
        // accumulator saturation
        add(0, 0, 1, 255, 0, 0,   256, 0, 0, 0, 0);
        add(0, 0, 1, 255, 0, 0,   512, 0, 0, 0, 0);
        add(0, 0, 1, 255, 0, 0,   768, 0, 0, 0, 0);
        add(0, 0, 1, 255, 0, 0,   1023, 0, 0, 0, 0);
        add(0, 0, 0, 0,   1, 0,   1022, 0, 0, 0, 0);
        add(0, 1, 0, 0,   0, 0,   0, 0, 0, 0, 0);
        // fill the FIFO, then overflow
        for (int k = 1; k <= 8; k++) add(0, 0, 1, 0, 0, 0, k, (k == 8), 0, 0, 0);
        add(0, 0, 1, 0,   0, 0,   9, 1, 0, 0, 1);
        add(0, 0, 0, 0,   0, 0,   9, 1, 0, 0, 1);
        add(0, 0, 0, 0,   1, 1,   8, 0, 0, 0, 1);
        add(0, 1, 0, 0,   0, 0,   0, 0, 0, 0, 0);
        // flush beats same-cycle handshakes
        add(0, 1, 1, 5,   1, 0,   0, 0, 0, 0, 0);
        add(0, 0, 0, 0,   1, 0,   0, 0, 1, 0, 0);
        add(0, 0, 0, 0,   0, 0,   0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].flush, tbl[i].aw, tbl[i].len, tbl[i].w, tbl[i].last);
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("v%0d accum", i), int'(accum), int'(e.e_accum));
            check($sformatf("v%0d stall", i), int'(aw_stall), int'(e.e_stall));
            check($sformatf("v%0d unexp", i), int'(w_unexp), int'(e.e_unexp));
            check($sformatf("v%0d lasterr", i), int'(w_lerr), int'(e.e_lerr));
            check($sformatf("v%0d ovf", i), int'(ovf), int'(e.e_ovf));
        end

        // budget: accum=5, len=2, divide-by-4 -> ((5+2+1)>>2)+1 = 3
        drive(1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("budget_accum", int'(accum), 5);
        drive(1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0);
        #1;
        check("budget_len2", int'(budget), 3);
        aw_len = 8'd0;
        #1;
        check("budget_len0", int'(budget), 2);
        aw_len = 8'd255;
        #1;
        check("budget_len255", int'(budget), 66);

        // tick: restart via reset, then one strobe every fourth cycle
        drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("tick_reset", int'(tick), 0);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("tick_c%0d", k), int'(tick), ((k % 4) == 3) ? 1 : 0);
        end
        // flush restarts the prescaler
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("tick_flush", int'(tick), 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("tick_f%0d", k), int'(tick), (k == 3) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
